div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Two-requester round-robin front end for a single sequential unsigned divider.
// One requester at a time is accepted in IDLE. Its operands are latched, and the
// quotient and remainder are produced by restoring division, one bit per cycle
// and MSB first. The result is then held in DONE until the consumer takes it.
// A zero divisor skips the iteration and reports q = all ones, r = a and
// divzero = 1.
//
// Ports
//   clk                 in   single clock; all state changes on its rising edge
//   rst                 in   synchronous, active-high reset
//   req0_valid          in   requester 0 has a division pending
//   req0_a, req0_b      in   requester 0 dividend / divisor (N bits, unsigned)
//   req0_ready          out  requester 0 operands accepted this cycle
//   req1_valid          in   requester 1 has a division pending
//   req1_a, req1_b      in   requester 1 dividend / divisor (N bits, unsigned)
//   req1_ready          out  requester 1 operands accepted this cycle
//   res_valid           out  a result is presented
//   res_ready           in   consumer takes the result this cycle
//   res_q, res_r        out  quotient / remainder (N bits), zero outside DONE
//   res_id              out  index of the requester served, zero outside DONE
//   res_divzero         out  divisor was zero, zero outside DONE
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_q,
    output logic [N-1:0] res_r,
    output logic         res_id,
    output logic         res_divzero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           last;      // requester served most recently
    logic           settle;    // first cycle after reset: no grants
    logic [N-1:0]   dvd;       // dividend, shifted left one bit per CALC cycle
    logic [N-1:0]   dvs;       // latched divisor
    logic [N:0]     rem;       // partial remainder, one guard bit wide
    logic [N-1:0]   quo;       // quotient, bits shifted in from the LSB
    logic           id;
    logic           divzero;
    logic [CW-1:0]  cnt;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic           grant;     // requester index that would be accepted
    logic           open;      // block may accept this cycle
    logic           transfer;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            // On a tie the requester that was not served last wins.
            grant = ~last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign open       = (state == IDLE) && !settle && !rst;
    assign req0_ready = open && req0_valid && !grant;
    assign req1_ready = open && req1_valid &&  grant;
    assign transfer   = req0_ready || req1_ready;
    assign sel_a      = grant ? req1_a : req0_a;
    assign sel_b      = grant ? req1_b : req0_b;

    // -------------------------------------------------------------------------
    // One restoring-division step
    // -------------------------------------------------------------------------
    logic [N:0]     trial;
    logic [N:0]     diff;
    logic           fits;

    always_comb begin
        // Remainder is always below the divisor, so its guard bit is zero and
        // shifting it out loses nothing.
        trial = (rem << 1) | (N + 1)'(dvd[N-1]);
        diff  = trial - {1'b0, dvs};
        fits  = (trial >= {1'b0, dvs});
    end

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            settle  <= 1'b1;
            quo     <= '0;
            rem     <= '0;
            id      <= 1'b0;
            divzero <= 1'b0;
            cnt     <= '0;
        end else begin
            settle <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        last <= grant;
                        id   <= grant;
                        dvs  <= sel_b;
                        cnt  <= '0;
                        if (sel_b == '0) begin
                            quo     <= '1;
                            rem     <= {1'b0, sel_a};
                            divzero <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dvd     <= sel_a;
                            quo     <= '0;
                            rem     <= '0;
                            divzero <= 1'b0;
                            state   <= CALC;
                        end
                    end
                end

                CALC: begin
                    dvd <= dvd << 1;
                    rem <= fits ? diff : trial;
                    quo <= {quo[N-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Result outputs: presented only in DONE and forced low while in reset
    // -------------------------------------------------------------------------
    logic show;

    assign show        = (state == DONE) && !rst;
    assign res_valid   = show;
    assign res_q       = show ? quo : '0;
    assign res_r       = show ? rem[N-1:0] : '0;
    assign res_id      = show && id;
    assign res_divzero = show && divzero;

endmodule
